// File: rtl/priority_grant_sequencer_pkg.sv
// Shared widths, FSM state and grant record for the priority grant sequencer.
package priority_grant_sequencer_pkg;

    localparam int REQ_W = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_OFFER
    } state_t;

    typedef struct packed {
        logic [REQ_W-1:0] onehot;
        logic [IDX_W-1:0] idx;
    } grant_t;

endpackage

// File: rtl/priority_grant_sequencer_if.sv
// Request/grant bus between a requester-side master and the sequencer.
interface priority_grant_sequencer_if;
    import priority_grant_sequencer_pkg::*;

    logic [REQ_W-1:0] req_set;
    logic [REQ_W-1:0] req_clr;
    logic             grant_ready;
    logic             grant_valid;
    logic [REQ_W-1:0] grant_onehot;
    logic [IDX_W-1:0] grant_idx;
    logic [REQ_W-1:0] pending;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output req_set, req_clr, grant_ready,
        input  grant_valid, grant_onehot, grant_idx, pending, grant_cnt
    );

    modport slave (
        input  req_set, req_clr, grant_ready,
        output grant_valid, grant_onehot, grant_idx, pending, grant_cnt
    );

endinterface

// File: rtl/prienc32_prefix.sv
// 32-bit highest-index-wins priority encoder built on a parallel-prefix suffix OR.
module prienc32_prefix
    import priority_grant_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req,
    output logic [REQ_W-1:0] onehot
);

    localparam int LVLS = $clog2(REQ_W);

    // sfx[LVLS][i] = |req[REQ_W-1:i], built in log2 levels (Kogge-Stone style)
    logic [LVLS:0][REQ_W-1:0] sfx;

    assign sfx[0] = req;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        for (genvar i = 0; i < REQ_W; i++) begin : g_bit
            if (i + (1 << l) < REQ_W) begin : g_or
                assign sfx[l+1][i] = sfx[l][i] | sfx[l][i + (1 << l)];
            end else begin : g_pass
                assign sfx[l+1][i] = sfx[l][i];
            end
        end
    end

    // a bit wins only if nothing above it is set
    assign onehot = req & ~{1'b0, sfx[LVLS][REQ_W-1:1]};

    a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(onehot));

endmodule

// File: rtl/priority_grant_sequencer_onehot32_to_bin.sv
// One-hot to binary index; an all-zero input maps to index 0.
module onehot32_to_bin
    import priority_grant_sequencer_pkg::*;
(
    input  logic [REQ_W-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/priority_grant_sequencer.sv
// Pending-request register with an IDLE/LOAD/OFFER grant sequencer; one
// highest-index grant is snapshotted per LOAD and held until its handshake.
module priority_grant_sequencer
    import priority_grant_sequencer_pkg::*;
#(
    parameter bit CLR_ON_GRANT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    priority_grant_sequencer_if.slave  bus
);

    state_t           state, state_d;
    logic [REQ_W-1:0] pending_q, pending_d, clr_mask;
    logic [REQ_W-1:0] enc_onehot;
    logic [IDX_W-1:0] enc_idx;
    grant_t           grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             handshake;

    prienc32_prefix u_prienc (
        .clk    (clk),
        .rst    (rst),
        .req    (pending_q),
        .onehot (enc_onehot)
    );

    onehot32_to_bin u_bin (
        .onehot (enc_onehot),
        .idx    (enc_idx)
    );

    assign handshake = (state == ST_OFFER) && valid_q && bus.grant_ready;

    // set beats clear on the same bit
    always_comb begin
        clr_mask = bus.req_clr;
        if (CLR_ON_GRANT && handshake) clr_mask = clr_mask | grant_q.onehot;
        pending_d = (pending_q & ~clr_mask) | bus.req_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // IDLE looks at the next pending value so a request reaches LOAD one cycle later
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:  if (pending_d != '0) state_d = ST_LOAD;
            ST_LOAD:  state_d = (pending_q != '0) ? ST_OFFER : ST_IDLE;
            ST_OFFER: if (handshake) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        valid_d = (state_d == ST_OFFER);
        cnt_d   = cnt_q + CNT_W'(handshake);
        if (state == ST_LOAD) begin
            grant_d.onehot = enc_onehot;
            grant_d.idx    = enc_idx;
        end
        // offer snapshot is only meaningful while valid; zero it on IDLE entry
        if (state_d == ST_IDLE) grant_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pending      = pending_q;
    assign bus.grant_valid  = valid_q;
    assign bus.grant_onehot = grant_q.onehot;
    assign bus.grant_idx    = grant_q.idx;
    assign bus.grant_cnt    = cnt_q;

endmodule

// File: doc/priority_grant_sequencer.md
PRIORITY_GRANT_SEQUENCER -- requirements
Module: priority_grant_sequencer

Interface
REQ-001 Parameter CLR_ON_GRANT, default 1, meaning: 1 = clear served pending bit on grant handshake; 0 = pending bits cleared only by req_clr.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_set  input  32  per-bit request pulse; sets pending bit.
REQ-005 req_clr  input  32  per-bit cancel pulse; clears pending bit.
REQ-006 grant_ready  input  1  consumer accepts grant when high with grant_valid.
REQ-007 grant_valid  output  1  grant offered.
REQ-008 grant_onehot  output  32  one-hot of highest-index pending bit at snapshot.
REQ-009 grant_idx  output  5  binary index of grant_onehot.
REQ-010 pending  output  32  registered pending vector.
REQ-011 grant_cnt  output  16  count of completed handshakes, wraps 0xFFFF->0x0000.

Function
REQ-012 Pending update per cycle: pending_next = (pending & ~clr_mask) | req_set; set SHALL win over clear on the same bit in the same cycle.
REQ-013 clr_mask = req_clr, OR'd with grant_onehot on a handshake cycle when CLR_ON_GRANT=1.
REQ-014 FSM states IDLE, LOAD, OFFER; encoding is local to the block.
REQ-015 IDLE: pending != 0 -> LOAD; else stay.
REQ-016 LOAD: register grant_onehot = highest set bit of pending (bit 31 highest priority), grant_idx = its index; -> OFFER; if pending == 0 in LOAD (all cancelled), -> IDLE with grant_onehot = 0.
REQ-017 OFFER: grant_valid = 1; grant_onehot/grant_idx SHALL hold stable until handshake regardless of new req_set/req_clr.
REQ-018 OFFER with grant_valid & grant_ready: grant_cnt increments, -> IDLE; grant_valid low next cycle.
REQ-019 req_clr of the granted bit during OFFER SHALL NOT withdraw the offer (no valid drop without handshake).
REQ-020 Latency: req_set in cycle N on empty pending -> pending visible N+1 -> LOAD N+1 -> grant_valid high N+2.
REQ-021 Throughput: one grant per 3 cycles max (OFFER, IDLE, LOAD); back-to-back grants SHALL re-evaluate priority from current pending.
REQ-022 A higher-priority req_set arriving during OFFER SHALL be served on the next LOAD, never preempt the current offer.
REQ-023 grant_onehot SHALL be all-zero and grant_idx 0 whenever grant_valid is low after IDLE entry.

Reset
REQ-024 rst high SHALL asynchronously force: state IDLE, pending 0, grant_valid 0, grant_onehot 0, grant_idx 0, grant_cnt 0.
REQ-025 rst asserted mid-OFFER SHALL drop grant_valid immediately with no count increment; in-flight grant is lost.
REQ-026 After rst deassertion first LOAD SHALL occur no earlier than one cycle after the first nonzero pending.

Structure
REQ-027 Shared package holds: 32-bit request width constant, 5-bit index width constant, 16-bit count width constant, FSM state typedef.
REQ-028 Priority one-hot computed by an instance of the team's 32-bit parallel-prefix priority encoder block (combinational, clk/rst tied through).
REQ-029 One sub-module: onehot32_to_bin (32-bit one-hot -> 5-bit index, zero input -> 0).
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 rst, then req_set=0x0000_0001 at cycle 0, grant_ready=1 -> grant_valid at cycle 2, grant_idx=0, onehot=0x1, pending=0 at cycle 3, grant_cnt=1.
REQ-032 req_set=0x8000_0401, ready=1 -> grants in order idx 31, 10, 0, each 3 cycles apart, grant_cnt=3.
REQ-033 req_set=0x0000_0010, ready=0 for 5 cycles, req_set=0x4000_0000 during OFFER -> idx 4 held stable 5 cycles; after ready, next grant idx 30.
REQ-034 Same cycle req_set[7]=1 and req_clr[7]=1 with pending[7]=1 -> pending[7] remains 1.
REQ-035 rst pulse during OFFER (idx 12) -> grant_valid, pending, grant_cnt all 0 same cycle, no grant after release.
REQ-036 grant_cnt preloaded via 65535 handshakes -> next handshake yields grant_cnt=0.
